// File: rtl/bru_resolve.sv
// Branch resolution stage: resolves BR/JAL/JALR, registers a link record toward
// writeback and holds a redirect toward the IFU on mispredict. Optional perf counters: BRU_PERF_CNT_EN.
module bru_resolve #(
    parameter int              XLEN   = 64,
    parameter logic [XLEN-1:0] RST_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic            in_cmp,
    input  logic [1:0]      in_kind,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_link,
    output logic            out_misalign,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_mispred_cnt
`endif
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_BR   = 2'd1;
    localparam logic [1:0] KIND_JAL  = 2'd2;
    localparam logic [1:0] KIND_JALR = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e          state_q, state_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_link_q, out_link_d;
    logic            out_misalign_q, out_misalign_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            accept;
    logic            taken;
    logic            mispredict;
    logic            misalign;
    logic            raise_redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign in_ready = !redirect_valid && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign link     = in_pc + XLEN'(4);
    assign jalr_sum = in_rs1 + in_imm;

    // Resolution: taken/target/mispredict from kind, compare and prediction
    always_comb begin
        taken      = 1'b0;
        mispredict = 1'b0;
        target     = in_pc + in_imm;
        unique case (in_kind)
            KIND_NONE: begin
                taken      = 1'b0;
                mispredict = 1'b0;
            end
            KIND_BR: begin
                taken      = in_cmp;
                mispredict = in_cmp != in_pred_taken;
            end
            KIND_JAL: begin
                taken      = 1'b1;
                mispredict = !in_pred_taken;
            end
            KIND_JALR: begin
                taken      = 1'b1;
                mispredict = 1'b1;
                target     = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: begin
                taken      = 1'b0;
                mispredict = 1'b0;
            end
        endcase
    end

    assign misalign       = taken && target[1];
    assign raise_redirect = accept && mispredict && !misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (raise_redirect) state_d = ST_PEND;
            ST_PEND: if (redirect_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = (state_q == ST_PEND);
        flush          = (state_q == ST_PEND) && redirect_ready;
    end

    // Output record: a new accept overrides a same-cycle drain
    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_link_d     = out_link_q;
        out_misalign_d = out_misalign_q;
        redirect_pc_d  = redirect_pc_q;
        if (accept) begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc;
            out_link_d     = link;
            out_misalign_d = misalign;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (raise_redirect) begin
            redirect_pc_d = taken ? target : link;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= RST_PC;
            out_link_q     <= '0;
            out_misalign_q <= 1'b0;
            redirect_pc_q  <= RST_PC;
        end else begin
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_link_q     <= out_link_d;
            out_misalign_q <= out_misalign_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_link     = out_link_q;
    assign out_misalign = out_misalign_q;
    assign redirect_pc  = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = sat_inc(br_cnt_q, accept && (in_kind != KIND_NONE));
        mp_cnt_d = sat_inc(mp_cnt_q, raise_redirect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign perf_br_cnt      = br_cnt_q;
    assign perf_mispred_cnt = mp_cnt_q;
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Randomized and directed bench for bru_resolve against a behavioural model of
// the resolution rules; counter checks are included when BRU_PERF_CNT_EN is defined.
module tb_bru_resolve;

    localparam int          XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [63:0] in_imm = '0;
    logic [63:0] in_rs1 = '0;
    logic        in_cmp = 1'b0;
    logic [1:0]  in_kind = 2'd0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [63:0] out_link;
    logic        out_misalign;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [63:0] redirect_pc;
    logic        flush;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    always #5 clk = ~clk;

    bru_resolve #(.XLEN(XLEN), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_cmp(in_cmp),
        .in_kind(in_kind), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_link(out_link), .out_misalign(out_misalign),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush)
`ifdef BRU_PERF_CNT_EN
        , .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    // Behavioural model state
    logic        m_ov = 1'b0;
    logic [63:0] m_opc = RST_PC;
    logic [63:0] m_olink = '0;
    logic        m_omis = 1'b0;
    logic        m_rv = 1'b0;
    logic [63:0] m_rpc = RST_PC;
    logic [31:0] m_brc = '0;
    logic [31:0] m_mpc = '0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_in_ready();
        return !m_rv && (!m_ov || out_ready);
    endfunction

    task automatic model_update();
        logic        acc;
        logic        tk;
        logic        mis;
        logic        mp;
        logic [63:0] tgt;
        if (rst) begin
            m_ov = 1'b0; m_opc = RST_PC; m_olink = '0; m_omis = 1'b0;
            m_rv = 1'b0; m_rpc = RST_PC; m_brc = '0; m_mpc = '0;
        end else begin
            acc = in_valid && m_in_ready();
            if (m_rv && redirect_ready) m_rv = 1'b0;
            if (acc) begin
                case (in_kind)
                    2'd0:    tk = 1'b0;
                    2'd1:    tk = in_cmp;
                    default: tk = 1'b1;
                endcase
                tgt = (in_kind == 2'd3) ? ((in_rs1 + in_imm) & ~64'd1) : (in_pc + in_imm);
                mis = tk && tgt[1];
                mp  = (in_kind == 2'd3) ? 1'b1 : (in_kind == 2'd0) ? 1'b0 : (tk != in_pred_taken);
                m_ov = 1'b1; m_opc = in_pc; m_olink = in_pc + 64'd4; m_omis = mis;
                if (in_kind != 2'd0 && m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 1;
                if (mp && !mis) begin
                    m_rv  = 1'b1;
                    m_rpc = tk ? tgt : in_pc + 64'd4;
                    if (m_mpc != 32'hFFFF_FFFF) m_mpc = m_mpc + 1;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        if (m_ov) begin
            chk("out_pc", out_pc, m_opc);
            chk("out_link", out_link, m_olink);
            chk("out_misalign", {63'd0, out_misalign}, {63'd0, m_omis});
        end
        chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_cnt", {32'd0, perf_br_cnt}, {32'd0, m_brc});
        chk("perf_mispred_cnt", {32'd0, perf_mispred_cnt}, {32'd0, m_mpc});
`endif
    endtask

    // One clock: combinational handshake checks, edge, registered-output checks
    task automatic step();
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_in_ready()});
        chk("flush", {63'd0, flush}, {63'd0, m_rv && redirect_ready});
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(input logic v, input logic [1:0] k, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [63:0] rs1,
                          input logic cmp, input logic pred);
        in_valid = v; in_kind = k; in_pc = pc; in_imm = imm; in_rs1 = rs1;
        in_cmp = cmp; in_pred_taken = pred;
    endtask

    initial begin
        logic [7:0] r8;
        // Reset: DUT is unknown before the first edge, so skip combinational checks
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            compare();
        end
        rst = 1'b0;
        #1;
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst flush", {63'd0, flush}, 64'd0);
        chk("rst out_misalign", {63'd0, out_misalign}, 64'd0);
        chk("rst out_pc", out_pc, 64'h8000_0000);
        chk("rst redirect_pc", redirect_pc, 64'h8000_0000);
        chk("rst out_link", out_link, 64'd0);
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);

        // Taken branch predicted not-taken
        out_ready = 1'b1; redirect_ready = 1'b0;
        set_in(1'b1, 2'd1, 64'h8000_0000, 64'h10, 64'h0, 1'b1, 1'b0);
        step();
        chk("br redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("br redirect_pc", redirect_pc, 64'h8000_0010);
        chk("br out_link", out_link, 64'h8000_0004);
        in_valid = 1'b0; redirect_ready = 1'b1;
        #1;
        chk("br flush high", {63'd0, flush}, 64'd1);
        step();
        #1;
        chk("br flush one cycle", {63'd0, flush}, 64'd0);
        chk("br in_ready after", {63'd0, in_ready}, 64'd1);

        // Not-taken branch predicted taken, redirect held for 3 cycles
        redirect_ready = 1'b0;
        set_in(1'b1, 2'd1, 64'h8000_0100, 64'h40, 64'h0, 1'b0, 1'b1);
        step();
        chk("nt redirect_pc", redirect_pc, 64'h8000_0104);
        set_in(1'b1, 2'd0, 64'h8000_0900, 64'h0, 64'h0, 1'b0, 1'b0);
        repeat (3) begin
            #1;
            chk("hold in_ready", {63'd0, in_ready}, 64'd0);
            step();
            chk("hold redirect_pc", redirect_pc, 64'h8000_0104);
        end
        in_valid = 1'b0; redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // JALR clears bit 0 of the target
        set_in(1'b1, 2'd3, 64'h8000_0200, 64'h4, 64'h8000_1001, 1'b0, 1'b0);
        step();
        chk("jalr redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("jalr redirect_pc", redirect_pc, 64'h8000_1004);
        in_valid = 1'b0; redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // JAL to a misaligned target
        set_in(1'b1, 2'd2, 64'h8000_0000, 64'h6, 64'h0, 1'b0, 1'b0);
        step();
        chk("jal out_misalign", {63'd0, out_misalign}, 64'd1);
        chk("jal no redirect", {63'd0, redirect_valid}, 64'd0);

        // Back-to-back pass-through, then stall for a cycle
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'd0, 64'h8000_0300 + 64'(4 * i), 64'h0, 64'h0, 1'b0, 1'b0);
            #1;
            chk("b2b in_ready", {63'd0, in_ready}, 64'd1);
            step();
            chk("b2b out_pc", out_pc, 64'h8000_0300 + 64'(4 * i));
        end
        out_ready = 1'b0;
        set_in(1'b1, 2'd0, 64'h8000_0400, 64'h0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("stall in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("stall out_pc", out_pc, 64'h8000_030C);
        out_ready = 1'b1;
        step();

        // Reset while a redirect is pending
        set_in(1'b1, 2'd2, 64'h8000_0500, 64'h100, 64'h0, 1'b0, 1'b0);
        step();
        chk("pend redirect_valid", {63'd0, redirect_valid}, 64'd1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("rst pend redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst pend out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst pend in_ready", {63'd0, in_ready}, 64'd1);
`ifdef BRU_PERF_CNT_EN
        chk("rst perf_br_cnt", {32'd0, perf_br_cnt}, 64'd0);
        chk("rst perf_mispred_cnt", {32'd0, perf_mispred_cnt}, 64'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r8 = 8'($urandom);
            in_valid       = ($urandom_range(0, 9) < 7);
            in_kind        = 2'($urandom_range(0, 3));
            in_cmp         = ($urandom_range(0, 1) == 1);
            in_pred_taken  = ($urandom_range(0, 1) == 1);
            in_imm         = {{56{r8[7]}}, r8} & ~64'd1;
            in_rs1         = {32'($urandom), 32'($urandom)};
            in_pc          = ($urandom_range(0, 9) == 0) ? {32'($urandom), 32'($urandom)} & ~64'd3
                                                         : 64'h8000_0000 + 64'($urandom_range(0, 16'hFFFF) & 32'hFFFC);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_ready = ($urandom_range(0, 1) == 1);
            rst            = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
